player_bullet_controller: RTL and testbench
===========================================

Name: player_bullet_controller

Overview:
- Owns the player bullet pool that feeds the fly enemy hit logic: spawns bullets at the player position on fire, moves them upward, retires them off-screen.
- Consumes the per-bullet hit pulses returned by the enemy stage and frees the matching slots.
- Runs in the 25 MHz pixel clock domain. Outputs are flat-packed 10-bit coordinates, matching the enemy controller's bullet inputs.

Parameters:
- BULLET_COUNT, 8, number of bullet slots; must be 8 to match the enemy controller inputs.
- MOVE_PERIOD, 20'd262143, clk25 cycles between movement steps.
- BULLET_SPEED, 4, pixels moved upward per movement step.
- FIRE_COOLDOWN, 16'd50000, minimum clk25 cycles between successful spawns.
- SPAWN_X_OFFSET, 15, added to player_x for the spawn x.
- SPAWN_Y_OFFSET, 8, subtracted from player_y for the spawn y.

Ports:
- clk25, input, 1, system clock.
- reset_n, input, 1, synchronous active-low reset.
- player_x, input, 10, player sprite left edge.
- player_y, input, 10, player sprite top edge.
- fire, input, 1, fire button; already synchronous to clk25.
- bullet_hit, input, BULLET_COUNT, one-cycle per-slot hit pulses from the enemy controller.
- bullet_x_flat, output, 10*BULLET_COUNT, slot k x at [k*10 +: 10].
- bullet_y_flat, output, 10*BULLET_COUNT, slot k y at [k*10 +: 10].
- bullet_active_flat, output, BULLET_COUNT, slot valid flags.
- fire_ok, output, 1, one-cycle pulse on a successful spawn.
- active_count, output, 4, number of active slots (registered).

Behaviour:
- Reset (reset_n low at a clk25 edge) clears all outputs, the move counter, the cooldown counter and fire_prev. Reset mid-flight kills every bullet in the next cycle.
- Move counter:
  - Increments each cycle.
  - On reaching MOVE_PERIOD, it returns to 0 and asserts an internal move_tick for that cycle.
- Fire request:
  - Without the option: fire & ~fire_prev (rising edge). fire_prev is registered every cycle.
  - A request is accepted only if the cooldown counter is 0 and at least one slot is free in the pre-cycle active vector.
  - A rejected request is dropped, not queued.
- Spawn:
  - Uses the lowest-index free slot.
  - Sets x = player_x + SPAWN_X_OFFSET and y = player_y - SPAWN_Y_OFFSET. If player_y < SPAWN_Y_OFFSET, y = 0.
  - Sets active = 1 and pulses fire_ok.
  - Loads the cooldown counter with FIRE_COOLDOWN.
  - All of this is visible on outputs the next cycle.
- Cooldown counter decrements by 1 each cycle while nonzero.
- Movement (on move_tick), for each active slot:
  - If y < BULLET_SPEED, clear active; x/y hold their last values.
  - Otherwise y -= BULLET_SPEED.
  - A slot spawned in the same cycle is not moved.
- Hit handling: bullet_hit[k] = 1 clears active[k] that cycle.
- Priority per slot: hit > move/retire. Simultaneous hit and move_tick gives a cleared slot, no y update.
- A slot freed this cycle (hit or retire) is not allocatable until the next cycle.
- bullet_hit on an inactive slot is ignored.
- Inactive slots keep stale x/y; consumers must gate on bullet_active_flat.
- active_count is the popcount of the registered active vector, one cycle behind it.
- All arithmetic is 10-bit unsigned. x wrap on overflow is permitted; player_x is bounded upstream.

Optional Feature:
- AUTO_FIRE_EN defined: the fire request is the fire level, so holding fire spawns one bullet each time the cooldown expires.
- AUTO_FIRE_EN undefined: rising edge only; holding fire spawns exactly one bullet.

Decomposition:
- Shared package (game_pkg): SCREEN_W = 640, SCREEN_H = 480, COORD_W = 10, SPRITE_SIZE = 32, MAX_BULLETS = 8.
- One natural sub-module: slot_alloc. It is a combinational lowest-free-index priority encoder with inputs active[BULLET_COUNT] and outputs idx and any_free.

Test Plan:
- Reset, then a fire pulse with player_x = 300, player_y = 440: next cycle slot 0 active, x = 315, y = 432, fire_ok pulses once.
- Two fire edges 10 cycles apart with FIRE_COOLDOWN = 50: second edge rejected, fire_ok stays 0, active_count stays 1.
- MOVE_PERIOD = 3, BULLET_SPEED = 4, bullet spawned at y = 10: y goes 6, then 2, then active clears on the third tick; x/y hold at 2.
- Fill all 8 slots, then fire again: rejected. Pulse bullet_hit[3] and fire in the same cycle: slot 3 cleared, spawn rejected. Fire one cycle later: slot 3 reused.
- bullet_hit[2] coincident with move_tick: slot 2 inactive, y unchanged. bullet_hit[5] on an inactive slot: no change.
- Hold fire for 200 cycles with FIRE_COOLDOWN = 50: one spawn without AUTO_FIRE_EN, four spawns with it.
- Pull reset_n low with 5 bullets in flight: next cycle all outputs are 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants for the pixel-clock video/game pipeline.
// Screen geometry, coordinate width, sprite size and bullet pool size.
package game_pkg;
   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;
   localparam int COORD_W     = 10;
   localparam int SPRITE_SIZE = 32;
   localparam int MAX_BULLETS = 8;
endpackage

// File: rtl/slot_alloc.sv
// Lowest-index free slot finder for the bullet pool (combinational).
// Ports: active (slot valid flags) -> idx (lowest free), any_free.
module slot_alloc
   import game_pkg::*;
#(
   parameter int N  = MAX_BULLETS,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  active,
   output logic [IW-1:0] idx,
   output logic          any_free
);

   // Scan from the top so the lowest free index wins.
   always_comb begin
      idx      = '0;
      any_free = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (!active[k]) begin
            idx      = IW'(k);
            any_free = 1'b1;
         end
      end
   end

endmodule

// File: rtl/player_bullet_controller.sv
// Player bullet pool: spawn on fire, move up on a timer, free on hit/exit.
// Ports: clk25, reset_n (sync, active low), player_x/y, fire, bullet_hit
//   -> bullet_x/y_flat (slot k at [k*10 +: 10]), bullet_active_flat,
//   fire_ok (spawn pulse), active_count (popcount, one cycle behind).
// Option: define AUTO_FIRE_EN to fire on the level instead of the edge.
module player_bullet_controller
   import game_pkg::*;
#(
   parameter int          BULLET_COUNT   = 8,
   parameter logic [19:0] MOVE_PERIOD    = 20'd262143,
   parameter int          BULLET_SPEED   = 4,
   parameter logic [15:0] FIRE_COOLDOWN  = 16'd50000,
   parameter int          SPAWN_X_OFFSET = 15,
   parameter int          SPAWN_Y_OFFSET = 8
) (
   input  logic                           clk25,
   input  logic                           reset_n,
   input  logic [9:0]                     player_x,
   input  logic [9:0]                     player_y,
   input  logic                           fire,
   input  logic [BULLET_COUNT-1:0]        bullet_hit,
   output logic [10*BULLET_COUNT-1:0]     bullet_x_flat,
   output logic [10*BULLET_COUNT-1:0]     bullet_y_flat,
   output logic [BULLET_COUNT-1:0]        bullet_active_flat,
   output logic                           fire_ok,
   output logic [3:0]                     active_count
);

   localparam int CW = COORD_W;
   localparam int IW = $clog2(BULLET_COUNT);
   localparam int FW = CW * BULLET_COUNT;

   localparam logic [CW-1:0] SPD = CW'(BULLET_SPEED);
   localparam logic [CW-1:0] SPX = CW'(SPAWN_X_OFFSET);
   localparam logic [CW-1:0] SPY = CW'(SPAWN_Y_OFFSET);

   logic [FW-1:0]           r_x;
   logic [FW-1:0]           r_y;
   logic [BULLET_COUNT-1:0] r_active;
   logic                    r_fire_ok;
   logic [3:0]              r_count;
   logic [19:0]             r_move_cnt;
   logic [15:0]             r_cooldown;
   logic                    r_fire_prev;

   logic [IW-1:0]           w_idx;
   logic                    w_any_free;
   logic                    w_req;
   logic                    w_tick;
   logic                    w_spawn;
   logic [CW-1:0]           w_spawn_x;
   logic [CW-1:0]           w_spawn_y;
   logic [FW-1:0]           w_x_n;
   logic [FW-1:0]           w_y_n;
   logic [BULLET_COUNT-1:0] w_act_n;
   logic [3:0]              w_count;

   // Allocation looks only at the registered vector, so a slot freed
   // this cycle cannot be reused until the next one.
   slot_alloc #(
      .N  (BULLET_COUNT),
      .IW (IW)
   ) u_alloc (
      .active   (r_active),
      .idx      (w_idx),
      .any_free (w_any_free)
   );

`ifdef AUTO_FIRE_EN
   assign w_req = fire;
`else
   assign w_req = fire & ~r_fire_prev;
`endif

   assign w_tick    = (r_move_cnt == MOVE_PERIOD);
   assign w_spawn   = w_req && (r_cooldown == 16'd0) && w_any_free;
   assign w_spawn_x = player_x + SPX;
   assign w_spawn_y = (player_y < SPY) ? '0 : player_y - SPY;

   always_comb begin
      w_x_n   = r_x;
      w_y_n   = r_y;
      w_act_n = r_active;
      w_count = '0;
      for (int k = 0; k < BULLET_COUNT; k++) begin
         w_count = w_count + {3'b000, r_active[k]};
         // Hit wins over movement; retired slots keep their last x/y.
         if (bullet_hit[k]) begin
            w_act_n[k] = 1'b0;
         end else if (w_tick && r_active[k]) begin
            if (r_y[k*CW +: CW] < SPD)
               w_act_n[k] = 1'b0;
            else
               w_y_n[k*CW +: CW] = r_y[k*CW +: CW] - SPD;
         end
         // Spawn targets a slot that was inactive, so it is never moved.
         if (w_spawn && (w_idx == IW'(k))) begin
            w_x_n[k*CW +: CW] = w_spawn_x;
            w_y_n[k*CW +: CW] = w_spawn_y;
            w_act_n[k]        = 1'b1;
         end
      end
   end

   always_ff @(posedge clk25) begin
      if (!reset_n) begin
         r_x         <= '0;
         r_y         <= '0;
         r_active    <= '0;
         r_fire_ok   <= 1'b0;
         r_count     <= '0;
         r_move_cnt  <= '0;
         r_cooldown  <= '0;
         r_fire_prev <= 1'b0;
      end else begin
         r_x         <= w_x_n;
         r_y         <= w_y_n;
         r_active    <= w_act_n;
         r_fire_ok   <= w_spawn;
         r_count     <= w_count;
         r_fire_prev <= fire;
         r_move_cnt  <= w_tick ? 20'd0 : r_move_cnt + 20'd1;
         if (w_spawn)
            r_cooldown <= FIRE_COOLDOWN;
         else if (r_cooldown != 16'd0)
            r_cooldown <= r_cooldown - 16'd1;
      end
   end

   assign bullet_x_flat      = r_x;
   assign bullet_y_flat      = r_y;
   assign bullet_active_flat = r_active;
   assign fire_ok            = r_fire_ok;
   assign active_count       = r_count;

endmodule

// File: tb/tb_player_bullet_controller.sv
// Bench for player_bullet_controller: per-cycle scoreboard plus
// directed corner cases (cooldown, retire, full pool, hit, reset).
module tb_player_bullet_controller;

   localparam int N   = 8;
   localparam int MP  = 3;
   localparam int SPD = 4;
   localparam int CD  = 50;

   logic          clk25 = 1'b0;
   logic          reset_n = 1'b0;
   logic [9:0]    player_x = '0;
   logic [9:0]    player_y = '0;
   logic          fire = 1'b0;
   logic [N-1:0]  bullet_hit = '0;
   logic [10*N-1:0] bullet_x_flat;
   logic [10*N-1:0] bullet_y_flat;
   logic [N-1:0]  bullet_active_flat;
   logic          fire_ok;
   logic [3:0]    active_count;

   player_bullet_controller #(
      .BULLET_COUNT  (N),
      .MOVE_PERIOD   (20'd3),
      .BULLET_SPEED  (SPD),
      .FIRE_COOLDOWN (16'd50)
   ) dut (
      .clk25              (clk25),
      .reset_n            (reset_n),
      .player_x           (player_x),
      .player_y           (player_y),
      .fire               (fire),
      .bullet_hit         (bullet_hit),
      .bullet_x_flat      (bullet_x_flat),
      .bullet_y_flat      (bullet_y_flat),
      .bullet_active_flat (bullet_active_flat),
      .fire_ok            (fire_ok),
      .active_count       (active_count)
   );

   always #20 clk25 = ~clk25;

   typedef struct packed {
      logic [10*N-1:0] x;
      logic [10*N-1:0] y;
      logic [N-1:0]    act;
      logic            fok;
      logic [3:0]      cnt;
   } exp_t;

   typedef struct {
      int px;
      int py;
      int ex;
      int ey;
   } vec_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   logic [9:0] m_x [N];
   logic [9:0] m_y [N];
   logic [N-1:0] m_act = '0;
   int   m_cnt = 0;
   int   m_cd = 0;
   logic m_prev = 1'b0;
   logic m_fok = 1'b0;
   logic [3:0] m_count = '0;

   task automatic chk(input string nm, input int got, input int want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   function automatic int dx(input int k);
      return int'(bullet_x_flat[k*10 +: 10]);
   endfunction

   function automatic int dy(input int k);
      return int'(bullet_y_flat[k*10 +: 10]);
   endfunction

   // Advance one clock: update the reference model from the inputs
   // now on the pins, queue its prediction, then compare after the edge.
   task automatic step();
      exp_t e;
      logic [N-1:0] nact;
      logic req, tick, ok;
      int idx;
      if (!reset_n) begin
         for (int k = 0; k < N; k++) begin
            m_x[k] = '0;
            m_y[k] = '0;
         end
         m_act = '0; m_cnt = 0; m_cd = 0;
         m_prev = 1'b0; m_fok = 1'b0; m_count = '0;
      end else begin
`ifdef AUTO_FIRE_EN
         req = fire;
`else
         req = fire && !m_prev;
`endif
         tick = (m_cnt == MP);
         idx = -1;
         for (int k = 0; k < N; k++)
            if (!m_act[k] && idx < 0) idx = k;
         ok = req && (m_cd == 0) && (idx >= 0);
         nact = m_act;
         for (int k = 0; k < N; k++) begin
            if (m_act[k]) begin
               if (bullet_hit[k]) nact[k] = 1'b0;
               else if (tick) begin
                  if (int'(m_y[k]) < SPD) nact[k] = 1'b0;
                  else m_y[k] = m_y[k] - 10'(SPD);
               end
            end
         end
         if (ok) begin
            m_x[idx] = player_x + 10'd15;
            m_y[idx] = (player_y < 10'd8) ? 10'd0 : player_y - 10'd8;
            nact[idx] = 1'b1;
         end
         m_count = 4'($countones(m_act));
         m_act = nact;
         m_cd = ok ? CD : (m_cd > 0 ? m_cd - 1 : 0);
         m_cnt = tick ? 0 : m_cnt + 1;
         m_prev = fire;
         m_fok = ok;
      end
      for (int k = 0; k < N; k++) begin
         e.x[k*10 +: 10] = m_x[k];
         e.y[k*10 +: 10] = m_y[k];
      end
      e.act = m_act;
      e.fok = m_fok;
      e.cnt = m_count;
      q.push_back(e);
      @(posedge clk25);
      #1;
      e = q.pop_front();
      n_chk++;
      if ({bullet_x_flat, bullet_y_flat, bullet_active_flat,
           fire_ok, active_count} != e) begin
         n_fail++;
         $display("FAIL scoreboard t=%0t: got x=%h y=%h act=%h fok=%b cnt=%0d, want x=%h y=%h act=%h fok=%b cnt=%0d",
                  $time, bullet_x_flat, bullet_y_flat, bullet_active_flat,
                  fire_ok, active_count, e.x, e.y, e.act, e.fok, e.cnt);
      end
      @(negedge clk25);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      fire = 1'b0;
      bullet_hit = '0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   vec_t tbl[5];
   int   ys[$];
   int   last, y_keep, y1_keep, nfok, guard;
   logic [N-1:0] act_keep;

   initial begin
      tbl[0] = '{px: 300,  py: 440, ex: 315, ey: 432};
      tbl[1] = '{px: 0,    py: 8,   ex: 15,  ey: 0};
      tbl[2] = '{px: 100,  py: 5,   ex: 115, ey: 0};
      tbl[3] = '{px: 1015, py: 100, ex: 6,   ey: 92};
      tbl[4] = '{px: 620,  py: 479, ex: 635, ey: 471};

      @(negedge clk25);
      do_reset();
      chk("reset_active", int'(bullet_active_flat), 0);
      chk("reset_count", int'(active_count), 0);
      chk("reset_fire_ok", int'(fire_ok), 0);
      chk("reset_xy_zero",
          int'(bullet_x_flat == '0 && bullet_y_flat == '0), 1);

      // Spawn position table, each from a fresh reset.
      for (int i = 0; i < 5; i++) begin
         do_reset();
         player_x = 10'(tbl[i].px);
         player_y = 10'(tbl[i].py);
         fire = 1'b1;
         step();
         chk("spawn_active", int'(bullet_active_flat), 1);
         chk("spawn_x", dx(0), tbl[i].ex);
         chk("spawn_y", dy(0), tbl[i].ey);
         chk("spawn_fire_ok", int'(fire_ok), 1);
         fire = 1'b0;
         step();
         chk("fire_ok_single", int'(fire_ok), 0);
         chk("count_lag", int'(active_count), 1);
      end

      // Second edge inside the cooldown window is dropped.
      do_reset();
      player_x = 10'd300;
      player_y = 10'd440;
      fire = 1'b1; step();
      fire = 1'b0; idle(9);
      fire = 1'b1; step();
      chk("cooldown_reject", int'(fire_ok), 0);
      fire = 1'b0; step();
      chk("cooldown_count", int'(active_count), 1);
      chk("cooldown_active", int'(bullet_active_flat), 1);

      // Upward motion and retirement off the top edge.
      do_reset();
      player_y = 10'd18;
      fire = 1'b1; step();
      fire = 1'b0;
      chk("move_start_y", dy(0), 10);
      ys.delete();
      last = 10;
      for (int i = 0; i < 40; i++) begin
         step();
         if (dy(0) != last) ys.push_back(dy(0));
         last = dy(0);
         if (!bullet_active_flat[0]) break;
      end
      chk("move_steps", ys.size(), 2);
      if (ys.size() == 2) begin
         chk("move_y1", ys[0], 6);
         chk("move_y2", ys[1], 2);
      end
      chk("retire_active", int'(bullet_active_flat[0]), 0);
      chk("retire_y_hold", dy(0), 2);

      // Fill the pool, then full / hit+fire / reuse corner cases.
      do_reset();
      player_y = 10'd479;
      for (int s = 0; s < N; s++) begin
         player_x = 10'(100 + s * 10);
         fire = 1'b1; step();
         chk("fill_fire_ok", int'(fire_ok), 1);
         chk("fill_x", dx(s), 115 + s * 10);
         fire = 1'b0; idle(50);
      end
      chk("fill_all", int'(bullet_active_flat), 255);
      fire = 1'b1; step();
      chk("full_reject", int'(fire_ok), 0);
      fire = 1'b0; step();
      bullet_hit = 8'h08;
      fire = 1'b1; step();
      chk("hit3_cleared", int'(bullet_active_flat[3]), 0);
      chk("hit3_same_cycle_reject", int'(fire_ok), 0);
      bullet_hit = '0;
      fire = 1'b0; step();
      player_x = 10'd777;
      fire = 1'b1; step();
      chk("reuse_fire_ok", int'(fire_ok), 1);
      chk("reuse_active", int'(bullet_active_flat), 255);
      chk("reuse_x", dx(3), 792);
      fire = 1'b0; step();

      // Hit on slot 2 in the same cycle as a movement step.
      guard = 0;
      while (m_cnt != MP && guard < 10) begin
         step();
         guard++;
      end
      chk("tick_found", int'(m_cnt == MP), 1);
      y_keep = dy(2);
      y1_keep = dy(1);
      bullet_hit = 8'h04; step();
      bullet_hit = '0;
      chk("hit2_cleared", int'(bullet_active_flat[2]), 0);
      chk("hit2_y_hold", dy(2), y_keep);
      chk("tick_moved_slot1", dy(1), y1_keep - SPD);

      // Hit on an already inactive slot changes nothing.
      bullet_hit = 8'h20; step();
      chk("hit5_cleared", int'(bullet_active_flat[5]), 0);
      act_keep = bullet_active_flat;
      y_keep = dy(5);
      bullet_hit = 8'h20; step();
      bullet_hit = '0;
      chk("hit5_idle_active", int'(bullet_active_flat), int'(act_keep));
      chk("hit5_idle_y", dy(5), y_keep);

      // Holding fire: one shot on edge, periodic shots with auto fire.
      do_reset();
      player_x = 10'd200;
      player_y = 10'd460;
      nfok = 0;
      fire = 1'b1;
      for (int i = 0; i < 200; i++) begin
         step();
         nfok += int'(fire_ok);
      end
      fire = 1'b0; step();
`ifdef AUTO_FIRE_EN
      chk("hold_spawns", nfok, 4);
`else
      chk("hold_spawns", nfok, 1);
`endif

      // Reset with five bullets in flight.
      do_reset();
      player_y = 10'd470;
      for (int s = 0; s < 5; s++) begin
         player_x = 10'(50 + s * 20);
         fire = 1'b1; step();
         fire = 1'b0; idle(50);
      end
      chk("five_in_flight", $countones(bullet_active_flat), 5);
      reset_n = 1'b0; step();
      chk("midreset_active", int'(bullet_active_flat), 0);
      chk("midreset_count", int'(active_count), 0);
      chk("midreset_fire_ok", int'(fire_ok), 0);
      chk("midreset_xy",
          int'(bullet_x_flat == '0 && bullet_y_flat == '0), 1);
      reset_n = 1'b1; step();
      chk("queue_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
